// File: rtl/cmd_proc_if.sv
// cmd_proc_if: command handshake between the UART command wrapper (master) and cmd_proc (slave).
interface cmd_proc_if;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic        send_resp;
   modport master (output cmd, cmd_rdy, input clr_cmd_rdy, send_resp);
   modport slave  (input cmd, cmd_rdy, output clr_cmd_rdy, send_resp);
endinterface

// File: rtl/cmd_proc.sv
// cmd_proc: Knight command sequencer (gyro cal, heading-then-move with speed ramps, tour start).
// Define CMD_PROC_ABORT_EN to let opcode F abort a move straight into ramp-down.
module cmd_proc #(
   parameter logic [9:0]  FRWRD_INC = 10'h020,
   parameter logic [9:0]  MAX_SPD   = 10'h300,
   parameter logic [11:0] ERR_THR   = 12'h02C
) (
   input  logic               clk,
   input  logic               rst_n,
   cmd_proc_if.slave          bus,
   output logic               strt_cal,
   input  logic               cal_done,
   input  logic               heading_rdy,
   input  logic signed [11:0] error,
   input  logic               cntrIR,
   output logic [11:0]        dsrd_hdng,
   output logic [9:0]         frwrd,
   output logic               moving,
   output logic               fanfare_go,
   output logic               tour_go
);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] CAL     = 3'd1;
   localparam logic [2:0] HEAD    = 3'd2;
   localparam logic [2:0] RAMP_UP = 3'd3;
   localparam logic [2:0] RAMP_DN = 3'd4;
   localparam logic [9:0] DN_STEP = FRWRD_INC << 1;
   logic [2:0]  state, nxt;
   logic [3:0]  squares, op;
   logic [4:0]  line_cnt;
   logic        fanfare_en, cntr_q;
   logic        new_cmd, is_move, rise, settled, reached, abort, done, in_move;
   logic [11:0] abs_err;
   logic [10:0] up_sum;
   logic [9:0]  frwrd_nxt;
   assign op      = bus.cmd[15:12];
   // rst_n gating keeps the command strobes quiet while reset is held with cmd_rdy up
   assign new_cmd = rst_n && state == IDLE && bus.cmd_rdy;
   assign is_move = new_cmd && (op == 4'b0010 || op == 4'b0011);
   assign in_move = state == HEAD || state == RAMP_UP;
   assign abs_err = error[11] ? -error : error;
   assign settled = abs_err < ERR_THR;
   assign rise    = cntrIR && !cntr_q;
   assign reached = state == RAMP_UP && line_cnt == {squares, 1'b0};
   assign done    = state == RAMP_DN && frwrd == '0;
   assign up_sum  = {1'b0, frwrd} + {1'b0, FRWRD_INC};
`ifdef CMD_PROC_ABORT_EN
   assign abort = in_move && bus.cmd_rdy && op == 4'hF;
`else
   assign abort = 1'b0;
`endif
   always_comb begin
      frwrd_nxt = (state == RAMP_UP || state == RAMP_DN) ? frwrd : '0;
      if (heading_rdy && state == RAMP_UP)
         frwrd_nxt = (up_sum > {1'b0, MAX_SPD}) ? MAX_SPD : up_sum[9:0];
      else if (heading_rdy && state == RAMP_DN)
         frwrd_nxt = (frwrd > DN_STEP) ? frwrd - DN_STEP : '0;
   end
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = !new_cmd ? IDLE : op == 4'b0000 ? CAL : is_move ? HEAD : IDLE;
         CAL:     nxt = cal_done ? IDLE : CAL;
         HEAD:    nxt = abort ? RAMP_DN : settled ? RAMP_UP : HEAD;
         RAMP_UP: nxt = (abort || reached) ? RAMP_DN : RAMP_UP;
         RAMP_DN: nxt = done ? IDLE : RAMP_DN;
         default: nxt = IDLE;
      endcase
   end
   assign bus.clr_cmd_rdy = new_cmd || abort;
   assign bus.send_resp   = (state == CAL && cal_done) || done;
   assign strt_cal        = new_cmd && op == 4'b0000;
   assign tour_go         = new_cmd && op == 4'b0100;
   assign fanfare_go      = reached && fanfare_en && !abort;
   assign moving          = in_move || (state == RAMP_DN && !done);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         frwrd      <= '0;
         dsrd_hdng  <= '0;
         squares    <= '0;
         line_cnt   <= '0;
         fanfare_en <= 1'b0;
         cntr_q     <= 1'b0;
      end else begin
         state  <= nxt;
         frwrd  <= frwrd_nxt;
         cntr_q <= cntrIR;
         if (is_move) begin
            dsrd_hdng  <= {bus.cmd[11:4], 4'h0};
            squares    <= bus.cmd[3:0];
            fanfare_en <= op[0];
            line_cnt   <= '0;
         end else if (rise && in_move && line_cnt != 5'd31)
            line_cnt <= line_cnt + 5'd1;
      end
   end
endmodule

// File: tb/tb_cmd_proc.sv
// tb_cmd_proc: vector table for decode plus hand sequences for moves, with a response scoreboard.
module tb_cmd_proc;
   logic clk, rst_n, cal_done, heading_rdy, cntrIR;
   logic signed [11:0] error;
   logic strt_cal, moving, fanfare_go, tour_go;
   logic [11:0] dsrd_hdng;
   logic [9:0] frwrd;
   cmd_proc_if bus();
   cmd_proc dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .strt_cal(strt_cal), .cal_done(cal_done),
      .heading_rdy(heading_rdy), .error(error), .cntrIR(cntrIR), .dsrd_hdng(dsrd_hdng),
      .frwrd(frwrd), .moving(moving), .fanfare_go(fanfare_go), .tour_go(tour_go)
   );
   typedef struct {
      logic [15:0] c;
      logic        clr;
      logic        cal;
      logic        tour;
      logic        resp;
   } vec_t;
   vec_t tbl[5];
   int checks = 0, errors = 0, fan_cnt = 0, clr_cnt = 0;
   logic [11:0] exp_q[$];
   logic s_clr, s_cal, s_tour, s_mov, seen;
   int e;
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
      checks++;
      if (a !== x) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", n, a, x);
      end
   endtask
   // just before each rising edge: scoreboard responses, count strobes
   always begin
      @(negedge clk);
      #4;
      if (bus.send_resp) begin
         chk("resp_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) chk("resp_hdng", dsrd_hdng, exp_q.pop_front());
      end
      if (fanfare_go) fan_cnt++;
      if (bus.clr_cmd_rdy) clr_cnt++;
   end
   task automatic tick();
      @(negedge clk);
   endtask
   task automatic send(input logic [15:0] c);
      @(negedge clk);
      bus.cmd = c;
      bus.cmd_rdy = 1'b1;
      #1;
      s_clr = bus.clr_cmd_rdy;
      s_cal = strt_cal;
      s_tour = tour_go;
      @(negedge clk);
      bus.cmd_rdy = 1'b0;
      #1;
      s_mov = moving;
   endtask
   task automatic hr();
      @(negedge clk);
      heading_rdy = 1'b1;
      @(negedge clk);
      heading_rdy = 1'b0;
      #1;
   endtask
   task automatic line();
      @(negedge clk);
      cntrIR = 1'b1;
      @(negedge clk);
      cntrIR = 1'b0;
   endtask
   task automatic drain(input string n);
      for (int k = 0; k < 40 && exp_q.size() > 0; k++) tick();
      chk(n, exp_q.size(), 0);
   endtask
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
   initial begin
      tbl[0] = '{16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[1] = '{16'h4000, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{16'h7000, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{16'h1ABC, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{16'hF000, 1'b1, 1'b0, 1'b0, 1'b0};
      rst_n = 1'b0;
      bus.cmd = '0;
      bus.cmd_rdy = 1'b0;
      cal_done = 1'b0;
      heading_rdy = 1'b0;
      cntrIR = 1'b0;
      error = 12'sh100;
      repeat (2) tick();
      chk("rst_frwrd", frwrd, 0);
      chk("rst_hdng", dsrd_hdng, 0);
      chk("rst_moving", moving, 0);
      chk("rst_strobes", {bus.clr_cmd_rdy, bus.send_resp, strt_cal, fanfare_go, tour_go}, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send(tbl[i].c);
         chk("dec_clr", s_clr, tbl[i].clr);
         chk("dec_cal", s_cal, tbl[i].cal);
         chk("dec_tour", s_tour, tbl[i].tour);
         chk("dec_moving", s_mov, 0);
         if (tbl[i].resp) begin
            exp_q.push_back(12'h000);
            repeat (100) tick();
            cal_done = 1'b1;
            tick();
            cal_done = 1'b0;
         end
         drain("dec_resp");
         chk("dec_hdng", dsrd_hdng, 0);
         chk("dec_frwrd", frwrd, 0);
      end
      // heading 0x3F, 2 squares: settle, ramp up to the cap, 4 lines, ramp down
      exp_q.push_back(12'h3F0);
      send(16'h23F2);
      chk("mv_clr", s_clr, 1);
      chk("mv_moving", s_mov, 1);
      chk("mv_hdng", dsrd_hdng, 12'h3F0);
      hr();
      chk("head_hold0", frwrd, 0);
      tick();
      error = -12'sd44;
      hr();
      chk("head_neg_thr", frwrd, 0);
      tick();
      error = 12'sh02C;
      hr();
      chk("head_pos_thr", frwrd, 0);
      tick();
      error = 12'sh010;
      e = 0;
      for (int k = 0; k < 26; k++) begin
         hr();
         e = (e + 32 > 768) ? 768 : e + 32;
         chk("ramp_up", frwrd, e);
      end
      repeat (3) line();
      hr();
      chk("hold_3lines", frwrd, 768);
      chk("moving_3lines", moving, 1);
      line();
      for (int k = 0; k < 12; k++) begin
         hr();
         e = (e > 64) ? e - 64 : 0;
         chk("ramp_dn", frwrd, e);
      end
      drain("mv_resp");
      chk("mv_done_moving", moving, 0);
      // fanfare on opcode 3 only
      fan_cnt = 0;
      exp_q.push_back(12'h000);
      send(16'h3001);
      repeat (3) hr();
      repeat (2) line();
      for (int k = 0; k < 30 && moving; k++) hr();
      drain("fan_resp");
      chk("fan_once", fan_cnt, 1);
      fan_cnt = 0;
      exp_q.push_back(12'h000);
      send(16'h3000);
      drain("sq0_resp");
      chk("sq0_fan", fan_cnt, 1);
      chk("sq0_frwrd", frwrd, 0);
      fan_cnt = 0;
      exp_q.push_back(12'h000);
      send(16'h2001);
      clr_cnt = 0;
      @(negedge clk);
      heading_rdy = 1'b1;
      bus.cmd = 16'hF000;
      bus.cmd_rdy = 1'b1;
`ifdef CMD_PROC_ABORT_EN
      #1;
      chk("abort_clr", bus.clr_cmd_rdy, 1);
      @(negedge clk);
      bus.cmd_rdy = 1'b0;
      for (int k = 0; k < 40 && moving; k++) tick();
      drain("abort_resp");
      heading_rdy = 1'b0;
      chk("abort_fan", fan_cnt, 0);
      chk("abort_clr_cnt", clr_cnt, 1);
`else
      repeat (3) tick();
      #1;
      chk("held_no_clr", bus.clr_cmd_rdy, 0);
      chk("held_moving", moving, 1);
      repeat (2) line();
      seen = 1'b0;
      for (int k = 0; k < 80 && !seen; k++) begin
         @(negedge clk);
         #1;
         if (bus.clr_cmd_rdy) seen = 1'b1;
      end
      chk("held_clr_seen", seen, 1);
      chk("held_clr_idle", moving, 0);
      @(negedge clk);
      bus.cmd_rdy = 1'b0;
      heading_rdy = 1'b0;
      tick();
      chk("held_clr_cnt", clr_cnt, 1);
      chk("held_fan", fan_cnt, 0);
      drain("held_resp");
`endif
      // reset mid ramp-up loses the command
      send(16'h2A55);
      repeat (3) hr();
      chk("pre_rst_frwrd", frwrd, 96);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_frwrd", frwrd, 0);
      chk("arst_moving", moving, 0);
      chk("arst_hdng", dsrd_hdng, 0);
      tick();
      rst_n = 1'b1;
      send(16'h4000);
      chk("post_rst_tour", s_tour, 1);
      chk("post_rst_moving", s_mov, 0);
      repeat (5) tick();
      chk("final_queue", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
